polyphonic_organ: RTL and testbench

Parametrised multi-voice square-wave tone generator: the next-generation organ core replacing fixed-frequency, fixed-four-key note synthesis. Each of NUM_VOICES voices owns a runtime-programmable phase-accumulator tuning word, a shared octave shift, and a gate that starts notes phase-aligned and lets notes finish their high half-period on release (no truncated pulses). It sits between the debounced key inputs and the audio output pins, and also drives a registered voice-count mix bus for a downstream DAC/PWM stage.

---
 rtl/polyphonic_organ.sv | 98 +++++++++
 tb/tb_polyphonic_organ.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/polyphonic_organ.sv
// Multi-voice square-wave organ core: per-voice phase accumulators with a runtime
// tuning word, shared octave shift, phase-aligned note start and full-pulse release.
module polyphonic_organ #(
  parameter int NUM_VOICES = 8,
  parameter int ACC_BITS   = 20,
  parameter int TUNE_BITS  = 19,
  parameter int VSEL_BITS  = 4
) (
  input  logic                                clock,
  input  logic                                reset,
  input  logic [NUM_VOICES-1:0]               keyPressed,
  input  logic [1:0]                          octaveSelect,
  input  logic                                tuneWrite,
  input  logic [VSEL_BITS-1:0]                tuneVoice,
  input  logic [TUNE_BITS-1:0]                tuneWord,
  output logic [NUM_VOICES-1:0]               noteOut,
  output logic [$clog2(NUM_VOICES+1)-1:0]     mixOut
);

  localparam int MIX_BITS = $clog2(NUM_VOICES + 1);
  localparam int PAD_BITS = ACC_BITS - TUNE_BITS;

  logic [TUNE_BITS-1:0] tune_q [NUM_VOICES];
  logic [TUNE_BITS-1:0] tune_d [NUM_VOICES];
  logic [ACC_BITS-1:0]  acc_q  [NUM_VOICES];
  logic [ACC_BITS-1:0]  acc_d  [NUM_VOICES];
  logic [ACC_BITS-1:0]  inc    [NUM_VOICES];
  logic [NUM_VOICES-1:0] gate_q, gate_d;
  logic [MIX_BITS-1:0]   mix_q, mix_d;
  logic [1:0]            shift;

  always_comb begin
    shift = 2'd3 - octaveSelect;
    for (int i = 0; i < NUM_VOICES; i++) begin
      inc[i] = {{PAD_BITS{1'b0}}, tune_q[i] >> shift};
    end
  end

  // Voice update priority: start on fresh press, release only in the low half, else run.
  always_comb begin
    for (int i = 0; i < NUM_VOICES; i++) begin
      // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
      tune_d[i] = tune_q[i];
      acc_d[i]  = acc_q[i];
      gate_d[i] = gate_q[i];
      if (keyPressed[i] && !gate_q[i]) begin
        gate_d[i] = 1'b1;
        acc_d[i]  = '0;
      end else if (!keyPressed[i] && gate_q[i] && !acc_q[i][ACC_BITS-1]) begin
        gate_d[i] = 1'b0;
        acc_d[i]  = '0;
      end else if (gate_q[i]) begin
        acc_d[i] = acc_q[i] + inc[i];
      end
      // Indices at or above NUM_VOICES never match, so such writes are dropped.
      if (tuneWrite && (int'(tuneVoice) == i)) begin
        tune_d[i] = tuneWord;
      end
    end
  end

  always_comb begin
    noteOut = '0;
    for (int i = 0; i < NUM_VOICES; i++) begin
      noteOut[i] = gate_q[i] & acc_q[i][ACC_BITS-1];
    end
  end

  always_comb begin
    mix_d = '0;
    for (int i = 0; i < NUM_VOICES; i++) begin
      mix_d = mix_d + MIX_BITS'(noteOut[i]);
    end
  end

  assign mixOut = mix_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      // NOTE: the tuning array is cleared on reset because a reset voice must stay silent until retuned.
      for (int i = 0; i < NUM_VOICES; i++) begin
        tune_q[i] <= '0;
        acc_q[i]  <= '0;
      end
      gate_q <= '0;
      mix_q  <= '0;
    end else begin
      // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
      for (int i = 0; i < NUM_VOICES; i++) begin
        tune_q[i] <= tune_d[i];
        acc_q[i]  <= acc_d[i];
      end
      gate_q <= gate_d;
      mix_q  <= mix_d;
    end
  end

endmodule

// File: tb/tb_polyphonic_organ.sv
// Self-checking bench for polyphonic_organ: directed scenarios plus random traffic,
// compared every cycle against an arithmetic reference model of the voices.
module tb_polyphonic_organ;

  localparam int NV   = 8;
  localparam int AB   = 20;
  localparam int TB   = 19;
  localparam int VB   = 4;
  localparam int MB   = $clog2(NV + 1);
  localparam int unsigned HALF = 1 << (AB - 1);
  localparam int unsigned MODV = 1 << AB;

  logic          clock = 1'b0;
  logic          reset;
  logic [NV-1:0] keyPressed;
  logic [1:0]    octaveSelect;
  logic          tuneWrite;
  logic [VB-1:0] tuneVoice;
  logic [TB-1:0] tuneWord;
  logic [NV-1:0] noteOut;
  logic [MB-1:0] mixOut;

  always #5 clock = ~clock;

  polyphonic_organ #(
    .NUM_VOICES(NV), .ACC_BITS(AB), .TUNE_BITS(TB), .VSEL_BITS(VB)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .keyPressed  (keyPressed),
    .octaveSelect(octaveSelect),
    .tuneWrite   (tuneWrite),
    .tuneVoice   (tuneVoice),
    .tuneWord    (tuneWord),
    .noteOut     (noteOut),
    .mixOut      (mixOut)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: phase value in [0, 2^AB), note is high in the upper half.
  int unsigned m_acc  [NV];
  int unsigned m_tune [NV];
  bit          m_gate [NV];
  int unsigned m_mix;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [NV-1:0] model_notes();
    logic [NV-1:0] r;
    for (int i = 0; i < NV; i++) r[i] = m_gate[i] && (m_acc[i] >= HALF);
    return r;
  endfunction

  task automatic model_step();
    int unsigned shift_amt;
    if (reset) begin
      for (int i = 0; i < NV; i++) begin
        m_acc[i] = 0; m_tune[i] = 0; m_gate[i] = 0;
      end
      m_mix = 0;
    end else begin
      shift_amt = 3 - int'(octaveSelect);
      m_mix = $countones(model_notes());
      for (int i = 0; i < NV; i++) begin
        if (keyPressed[i] && !m_gate[i]) begin
          m_gate[i] = 1; m_acc[i] = 0;
        end else if (!keyPressed[i] && m_gate[i] && m_acc[i] < HALF) begin
          m_gate[i] = 0; m_acc[i] = 0;
        end else if (m_gate[i]) begin
          m_acc[i] = (m_acc[i] + (m_tune[i] >> shift_amt)) % MODV;
        end
      end
      if (tuneWrite && int'(tuneVoice) < NV) m_tune[tuneVoice] = int'(tuneWord);
    end
  endtask

  // Advance the model with the inputs the DUT is about to sample, then compare after the edge.
  task automatic tick();
    model_step();
    @(posedge clock);
    #1;
    check("note", 32'(noteOut), 32'(model_notes()));
    check("mix", 32'(mixOut), m_mix);
  endtask

  task automatic write_tune(input int v, input int unsigned w);
    tuneWrite = 1'b1;
    tuneVoice = VB'(v);
    tuneWord  = TB'(w);
    tick();
    tuneWrite = 1'b0;
  endtask

  // Idle all keys, then press voice 0 and compare against an ideal square of period p.
  task automatic period_check(input int oct);
    int p;
    p = 4 << (3 - oct);
    keyPressed   = '0;
    octaveSelect = 2'(oct);
    repeat (40) tick();
    keyPressed[0] = 1'b1;
    tick();
    for (int k = 0; k < 2 * p; k++) begin
      check($sformatf("period_oct%0d_k%0d", oct, k), 32'(noteOut[0]), 32'((k % p) >= p / 2));
      tick();
    end
  endtask

  initial begin
    int mix_exp [5] = '{0, 0, 4, 4, 0};

    // Reset with keys held and writes active: outputs must stay quiet.
    reset = 1'b1; keyPressed = '1; octaveSelect = 2'd3;
    tuneWrite = 1'b1; tuneVoice = '0; tuneWord = 19'h40000;
    repeat (3) begin
      tick();
      check("reset_note", 32'(noteOut), 32'd0);
      check("reset_mix", 32'(mixOut), 32'd0);
    end
    reset = 1'b0; tuneWrite = 1'b0;
    repeat (6) begin
      tick();
      check("post_reset_silent", 32'(noteOut), 32'd0);
    end

    // Octave sweep on voice 0.
    write_tune(0, 32'h40000);
    period_check(3);
    period_check(2);
    period_check(0);

    // Release on the first high cycle: the pulse completes, then goes low.
    keyPressed = '0; octaveSelect = 2'd3;
    repeat (20) tick();
    keyPressed[0] = 1'b1;
    repeat (3) tick();
    check("rel_first_high", 32'(noteOut[0]), 32'd1);
    keyPressed[0] = 1'b0;
    tick();
    check("rel_remaining_high", 32'(noteOut[0]), 32'd1);
    tick();
    check("rel_then_low", 32'(noteOut[0]), 32'd0);
    repeat (4) tick();

    // Four voices pressed together: mix follows noteOut one cycle later.
    for (int v = 1; v < 4; v++) write_tune(v, 32'h40000);
    keyPressed = '0;
    repeat (10) tick();
    keyPressed = 8'h0F;
    tick();
    for (int k = 0; k < 5; k++) begin
      tick();
      check($sformatf("mix4_k%0d", k + 1), 32'(mixOut), mix_exp[k]);
    end
    write_tune(NV, 32'h7FFFF);
    repeat (12) tick();

    // Reset pulse mid-note with key 0 held.
    keyPressed = 8'h01;
    repeat (6) tick();
    reset = 1'b1;
    tick();
    check("midreset_note0", 32'(noteOut[0]), 32'd0);
    reset = 1'b0;
    repeat (8) begin
      tick();
      check("midreset_silent", 32'(noteOut[0]), 32'd0);
    end
    write_tune(0, 32'h40000);
    repeat (12) tick();

    // Random traffic against the model.
    for (int t = 0; t < 800; t++) begin
      for (int i = 0; i < NV; i++)
        if ($urandom_range(0, 15) == 0) keyPressed[i] = ~keyPressed[i];
      if ($urandom_range(0, 31) == 0) octaveSelect = 2'($urandom_range(0, 3));
      tuneWrite = ($urandom_range(0, 7) == 0);
      tuneVoice = VB'($urandom_range(0, 15));
      case ($urandom_range(0, 3))
        0:       tuneWord = '0;
        1:       tuneWord = 19'h40000;
        2:       tuneWord = TB'($urandom_range(1, 4096) << 4);
        default: tuneWord = TB'($urandom);
      endcase
      reset = ($urandom_range(0, 199) == 0);
      tick();
    end
    reset = 1'b0; tuneWrite = 1'b0;

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
